// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use / memory-wait hazard control.
// fwd_sel, stall, bubble and freeze are combinational decisions for the current
// cycle. Only the stall FSM, its remaining-cycle counter and stall_count are
// registered.
module fwd_hazard_unit #(
    parameter int unsigned NSRC      = 2,
    parameter int unsigned NSTAGE    = 2,
    parameter int unsigned REGBITS   = 5,
    parameter int unsigned LU_CYCLES = 1,
    localparam int unsigned SELW     = $clog2(NSTAGE + 1)
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NSRC*REGBITS-1:0]    ex_rs_addr,
    input  logic [NSRC-1:0]            ex_rs_valid,
    input  logic [NSRC*REGBITS-1:0]    id_rs_addr,
    input  logic [NSRC-1:0]            id_rs_valid,
    input  logic [NSTAGE*REGBITS-1:0]  dest_addr,
    input  logic [NSTAGE-1:0]          dest_wen,
    input  logic                       ex_memread,
    input  logic [REGBITS-1:0]         ex_dest,
    input  logic                       mem_req,
    input  logic                       dmem_ready,
    output logic [NSRC*SELW-1:0]       fwd_sel,
    output logic                       stall,
    output logic                       bubble,
    output logic                       freeze,
    output logic [7:0]                 stall_count
);

    localparam int unsigned CNTW     = 4;
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LU_CYCLES - 1);
    localparam logic LU_MULTI        = (LU_CYCLES > 1);

    typedef enum logic {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNTW-1:0]   lu_cnt;
    logic [CNTW-1:0]   lu_cnt_nxt;
    logic              lu_hit;
    logic              mem_wait;

    // Forwarding select: scan far-to-near so the nearest matching stage wins.
    always_comb begin
        fwd_sel = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (ex_rs_valid[k]) begin
                for (int s = int'(NSTAGE) - 1; s >= 0; s--) begin
                    if (dest_wen[s] &&
                        (dest_addr[s*REGBITS +: REGBITS] == ex_rs_addr[k*REGBITS +: REGBITS]) &&
                        (dest_addr[s*REGBITS +: REGBITS] != '0)) begin
                        fwd_sel[k*SELW +: SELW] = SELW'(s + 1);
                    end
                end
            end
        end
    end

    // Load in ID/EX whose result is needed by the instruction in IF/ID.
    always_comb begin
        lu_hit = 1'b0;
        if (ex_memread && (ex_dest != '0)) begin
            for (int k = 0; k < int'(NSRC); k++) begin
                if (id_rs_valid[k] && (id_rs_addr[k*REGBITS +: REGBITS] == ex_dest)) begin
                    lu_hit = 1'b1;
                end
            end
        end
    end

    // Data memory still busy: the whole pipeline must wait.
    always_comb begin
        mem_wait = mem_req & ~dmem_ready;
    end

    // Stall FSM state and remaining-cycle counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            lu_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
        end
    end

    // Next state: frozen cycles hold everything and ignore new hazards.
    always_comb begin
        state_nxt  = state;
        lu_cnt_nxt = lu_cnt;
        if (!mem_wait) begin
            case (state)
                IDLE: begin
                    if (lu_hit && LU_MULTI) begin
                        state_nxt  = LU_STALL;
                        lu_cnt_nxt = CNT_INIT;
                    end
                end
                LU_STALL: begin
                    if (lu_cnt <= CNTW'(1)) begin
                        state_nxt  = IDLE;
                        lu_cnt_nxt = '0;
                    end else begin
                        lu_cnt_nxt = lu_cnt - CNTW'(1);
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    lu_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Control outputs; all forced low while reset is asserted.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        freeze = 1'b0;
        if (nRST) begin
            freeze = mem_wait;
            if (mem_wait) begin
                stall = 1'b1;
            end else if ((state == LU_STALL) || lu_hit) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    // Saturating count of cycles lost to stall or freeze.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_count <= '0;
        end else if ((stall || freeze) && (stall_count != 8'hFF)) begin
            stall_count <= stall_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: a driver applies inputs at the falling
// edge and queues the reference model's expectation; a monitor pops and checks.
module tb_fwd_hazard_unit;

    localparam int unsigned NSRC      = 2;
    localparam int unsigned NSTAGE    = 2;
    localparam int unsigned REGBITS   = 5;
    localparam int unsigned LU_CYCLES = 3;
    localparam int unsigned SELW      = $clog2(NSTAGE + 1);

    logic                      CLK;
    logic                      nRST;
    logic [NSRC*REGBITS-1:0]   ex_rs_addr;
    logic [NSRC-1:0]           ex_rs_valid;
    logic [NSRC*REGBITS-1:0]   id_rs_addr;
    logic [NSRC-1:0]           id_rs_valid;
    logic [NSTAGE*REGBITS-1:0] dest_addr;
    logic [NSTAGE-1:0]         dest_wen;
    logic                      ex_memread;
    logic [REGBITS-1:0]        ex_dest;
    logic                      mem_req;
    logic                      dmem_ready;
    logic [NSRC*SELW-1:0]      fwd_sel;
    logic                      stall;
    logic                      bubble;
    logic                      freeze;
    logic [7:0]                stall_count;

    typedef struct packed {
        logic [NSRC*SELW-1:0] fwd;
        logic                 stall;
        logic                 bubble;
        logic                 freeze;
        logic [7:0]           cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_rem    = 0;   // load-use cycles still owed after the current one
    int   m_cnt    = 0;   // cycles stalled or frozen so far, capped at 255

    fwd_hazard_unit #(
        .NSRC      (NSRC),
        .NSTAGE    (NSTAGE),
        .REGBITS   (REGBITS),
        .LU_CYCLES (LU_CYCLES)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ex_rs_addr  (ex_rs_addr),
        .ex_rs_valid (ex_rs_valid),
        .id_rs_addr  (id_rs_addr),
        .id_rs_valid (id_rs_valid),
        .dest_addr   (dest_addr),
        .dest_wen    (dest_wen),
        .ex_memread  (ex_memread),
        .ex_dest     (ex_dest),
        .mem_req     (mem_req),
        .dmem_ready  (dmem_ready),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .bubble      (bubble),
        .freeze      (freeze),
        .stall_count (stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Nearest producing stage, or 0 for the register file.
    function automatic logic [NSRC*SELW-1:0] model_fwd();
        logic [NSRC*SELW-1:0] r;
        logic [REGBITS-1:0]   src;
        logic [REGBITS-1:0]   dst;
        int                   sel;
        r = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            sel = 0;
            src = ex_rs_addr[k*REGBITS +: REGBITS];
            if (ex_rs_valid[k]) begin
                for (int s = 0; s < int'(NSTAGE); s++) begin
                    dst = dest_addr[s*REGBITS +: REGBITS];
                    if (dest_wen[s] && dst == src && dst != 0) begin
                        sel = s + 1;
                        break;
                    end
                end
            end
            r[k*SELW +: SELW] = SELW'(sel);
        end
        return r;
    endfunction

    function automatic logic model_hit();
        logic h;
        h = 1'b0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (ex_memread && ex_dest != 0 && id_rs_valid[k] &&
                id_rs_addr[k*REGBITS +: REGBITS] == ex_dest) begin
                h = 1'b1;
            end
        end
        return h;
    endfunction

    // Queue this cycle's expectation, advance the model past the next rising edge.
    task automatic commit();
        exp_t e;
        logic frz;
        frz   = mem_req & ~dmem_ready;
        e.fwd = model_fwd();
        if (!nRST) begin
            e.stall  = 1'b0;
            e.bubble = 1'b0;
            e.freeze = 1'b0;
            e.cnt    = 8'd0;
            m_rem    = 0;
            m_cnt    = 0;
        end else begin
            e.cnt    = 8'(m_cnt);
            e.freeze = frz;
            if (frz) begin
                e.stall  = 1'b1;
                e.bubble = 1'b0;
            end else if (m_rem > 0) begin
                e.stall  = 1'b1;
                e.bubble = 1'b1;
                m_rem    = m_rem - 1;
            end else if (model_hit()) begin
                e.stall  = 1'b1;
                e.bubble = 1'b1;
                m_rem    = LU_CYCLES - 1;
            end else begin
                e.stall  = 1'b0;
                e.bubble = 1'b0;
            end
            if ((e.stall || e.freeze) && m_cnt < 255) m_cnt = m_cnt + 1;
        end
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        ex_rs_addr  = '0;
        ex_rs_valid = '0;
        id_rs_addr  = '0;
        id_rs_valid = '0;
        dest_addr   = '0;
        dest_wen    = '0;
        ex_memread  = 1'b0;
        ex_dest     = '0;
        mem_req     = 1'b0;
        dmem_ready  = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        commit();
        nRST = 1'b1;
        commit();
    endtask

    task automatic set_load(input logic [REGBITS-1:0] r);
        ex_memread              = 1'b1;
        ex_dest                 = r;
        id_rs_addr[0 +: REGBITS] = r;
        id_rs_valid[0]          = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fwd_sel",     32'(fwd_sel),     32'(e.fwd));
                chk("stall",       32'(stall),       32'(e.stall));
                chk("bubble",      32'(bubble),      32'(e.bubble));
                chk("freeze",      32'(freeze),      32'(e.freeze));
                chk("stall_count", 32'(stall_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        nRST = 1'b0;
        @(negedge CLK);

        // Reset: hazards present but outputs forced low; forwarding still live.
        set_load(5'd7);
        mem_req    = 1'b1;
        dmem_ready = 1'b0;
        ex_rs_addr[0 +: REGBITS] = 5'd5;
        ex_rs_valid = 2'b01;
        dest_addr   = {5'd5, 5'd5};
        dest_wen    = 2'b11;
        commit();
        commit();
        nRST = 1'b1;
        clear_inputs();
        commit();

        // Forward priority and zero register.
        ex_rs_addr[0 +: REGBITS] = 5'd5;
        ex_rs_valid = 2'b01;
        dest_addr   = {5'd5, 5'd5};
        dest_wen    = 2'b11;
        commit();
        dest_wen    = 2'b10;
        commit();
        ex_rs_addr  = {5'd0, 5'd5};
        ex_rs_valid = 2'b11;
        dest_addr   = {5'd5, 5'd0};
        dest_wen    = 2'b01;
        commit();
        dest_wen    = 2'b11;
        commit();

        // Load-use: three stall cycles, then count settles at 3.
        do_reset();
        set_load(5'd7);
        commit();
        ex_memread = 1'b0;
        repeat (4) commit();

        // Freeze in the middle of the load-use stall: five lost cycles.
        do_reset();
        set_load(5'd7);
        commit();
        ex_memread = 1'b0;
        commit();
        mem_req    = 1'b1;
        dmem_ready = 1'b0;
        repeat (2) commit();
        mem_req    = 1'b0;
        dmem_ready = 1'b1;
        repeat (3) commit();

        // Hazard coinciding with freeze starts only once unfrozen.
        do_reset();
        set_load(5'd9);
        mem_req    = 1'b1;
        dmem_ready = 1'b0;
        commit();
        dmem_ready = 1'b1;
        commit();
        ex_memread = 1'b0;
        repeat (3) commit();

        // Reset during the second LU_STALL cycle aborts at once.
        do_reset();
        set_load(5'd7);
        commit();
        ex_memread = 1'b0;
        commit();
        nRST = 1'b0;
        commit();
        nRST = 1'b1;
        repeat (2) commit();

        // Saturation: 300 frozen cycles.
        do_reset();
        mem_req    = 1'b1;
        dmem_ready = 1'b0;
        repeat (300) commit();
        mem_req    = 1'b0;
        commit();

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            nRST        = ($urandom_range(0, 49) != 0);
            ex_rs_addr  = {REGBITS'($urandom_range(0, 7)), REGBITS'($urandom_range(0, 7))};
            ex_rs_valid = NSRC'($urandom_range(0, 3));
            id_rs_addr  = {REGBITS'($urandom_range(0, 7)), REGBITS'($urandom_range(0, 7))};
            id_rs_valid = NSRC'($urandom_range(0, 3));
            dest_addr   = {REGBITS'($urandom_range(0, 7)), REGBITS'($urandom_range(0, 7))};
            dest_wen    = NSTAGE'($urandom_range(0, 3));
            ex_memread  = ($urandom_range(0, 2) == 0);
            ex_dest     = REGBITS'($urandom_range(0, 7));
            mem_req     = ($urandom_range(0, 3) == 0);
            dmem_ready  = ($urandom_range(0, 1) == 0);
            commit();
        end

        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port SHALL be named CLK and the reset port nRST.
REQ-002 Parameter NSRC, default 2, SHALL set the number of source operands per instruction.
REQ-003 Parameter NSTAGE, default 2, SHALL set the number of downstream write-back stages that can forward; index 0 is nearest (EX/MEM).
REQ-004 Parameter REGBITS, default 5, SHALL set the register-address width.
REQ-005 Parameter LU_CYCLES, default 1 (range 1..15), SHALL set the load-use stall length in cycles.
REQ-006 Derived constant SELW SHALL equal $clog2(NSTAGE+1).
REQ-007 Ports SHALL be:
- CLK, input, 1: clock.
- nRST, input, 1: async active-low reset.
- ex_rs_addr, input, NSRC*REGBITS: source registers of the ID/EX instruction.
- ex_rs_valid, input, NSRC: source k is actually read.
- id_rs_addr, input, NSRC*REGBITS: source registers of the IF/ID instruction.
- id_rs_valid, input, NSRC: IF/ID source k is actually read.
- dest_addr, input, NSTAGE*REGBITS: destination register per stage.
- dest_wen, input, NSTAGE: stage writes the register file.
- ex_memread, input, 1: ID/EX instruction is a load.
- ex_dest, input, REGBITS: ID/EX destination register.
- mem_req, input, 1: EX/MEM holds a data-memory access.
- dmem_ready, input, 1: data memory completes this cycle.
- fwd_sel, output, NSRC*SELW: 0 selects the register file; value s selects stage s-1.
- stall, output, 1: hold PC and IF/ID.
- bubble, output, 1: load a nop into ID/EX.
- freeze, output, 1: hold every pipeline register.
- stall_count, output, 8: saturating count of stalled cycles.

Function
REQ-008 fwd_sel SHALL be combinational; for each source k with ex_rs_valid[k]=1, it SHALL be s+1 for the lowest s with dest_wen[s]=1, dest_addr[s]==ex_rs_addr[k], and dest_addr[s]!=0; otherwise it SHALL be 0.
REQ-009 When several stages match, the nearest (lowest index) SHALL win; register 0 SHALL never forward.
REQ-010 The FSM SHALL have states IDLE and LU_STALL, plus a 4-bit remaining-cycle counter lu_cnt.
REQ-011 A hazard, lu_hit, SHALL exist when ex_memread=1, ex_dest!=0, and ex_dest equals some id_rs_addr[k] with id_rs_valid[k]=1.
REQ-012 In IDLE, lu_hit=1 SHALL assert stall=1 and bubble=1 in the same cycle.
REQ-013 In IDLE with lu_hit=1 and LU_CYCLES>1, the FSM SHALL go to LU_STALL with lu_cnt=LU_CYCLES-1; with LU_CYCLES=1 it SHALL remain in IDLE.
REQ-014 In LU_STALL, stall=1 and bubble=1, lu_cnt SHALL decrement each unfrozen cycle, and the FSM SHALL return to IDLE in the cycle after lu_cnt reaches 1.
REQ-015 freeze SHALL equal mem_req & ~dmem_ready (combinational).
REQ-016 While freeze=1, stall=1, bubble=0, state and lu_cnt SHALL hold, and new lu_hit SHALL be ignored.
REQ-017 stall_count SHALL increment by 1 on each rising CLK edge where stall|freeze=1, and SHALL saturate at 255.
REQ-018 lu_hit and freeze in the same cycle SHALL yield freeze=1, stall=1, bubble=0; the load-use stall SHALL begin on the first unfrozen cycle.

Reset
REQ-019 While nRST=0, state SHALL be IDLE, lu_cnt=0, and stall_count=0; stall, bubble, and freeze SHALL be forced to 0.
REQ-020 fwd_sel SHALL remain a pure function of its inputs during reset.
REQ-021 Reset asserted mid-LU_STALL SHALL abort the stall immediately (asynchronously).

Verification
REQ-022 The bench SHALL cover:
- Forward priority: ex_rs_addr[0]=5, dest_addr={5,5}, dest_wen={1,1} -> fwd_sel[0]=1; with dest_wen[0]=0 -> fwd_sel[0]=2.
- Zero register: ex_rs_addr[1]=0, dest_addr[0]=0, dest_wen[0]=1 -> fwd_sel[1]=0.
- Load-use: LU_CYCLES=3, ex_memread=1, ex_dest=7, id_rs_addr[0]=7 -> stall=bubble=1 for exactly 3 cycles, then stall_count=3.
- Freeze during LU_STALL: mem_req=1, dmem_ready=0 for 2 cycles -> bubble=0 and lu_cnt holds; total stall+freeze = 5 cycles; stall_count=5.
- Saturation: 300 consecutive freeze cycles -> stall_count=255.
- Reset mid-stall: nRST=0 in the 2nd LU_STALL cycle -> stall=0 at once, and IDLE after release.
